// File: rtl/rv32_mc_control.sv
// rv32_mc_control: main control FSM of the multicycle reduced-ISA RV32 core.
// Sequences fetch/decode/execute/memory/write-back and Moore-decodes every
// datapath control from the current state. Memory states are stretched by
// MEM_WAIT extra cycles through a 4-bit wait counter; write enables pulse only
// in the last cycle of a memory state, so each is one cycle per state visit.
// Optional feature macro: RV32_MC_ILLEGAL_TRAP_EN (illegal decode -> TRAP, halt).
module rv32_mc_control #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clockCPU,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [3:0] estado,
    output logic       EscrevePC,
    output logic       EscrevePCCond,
    output logic       IouD,
    output logic       EscreveMem,
    output logic       LeMem,
    output logic       EscreveIR,
    output logic       EscreveReg,
    output logic [1:0] Mem2Reg,
    output logic [1:0] OrigPC,
    output logic [1:0] OrigAULA,
    output logic [1:0] OrigBULA,
    output logic [1:0] ALUOp,
    output logic       halt
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_ALU_WB   = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_EXEC_I   = 4'd10;
`ifdef RV32_MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd15;
    localparam logic [3:0] S_ILLEGAL  = S_TRAP;
`else
    localparam logic [3:0] S_ILLEGAL  = S_FETCH;
`endif

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    logic [3:0] state_reg, state_next;
    logic [3:0] wait_reg, wait_next;
    logic       wait_done;
    logic       pc_we, pcc_we, mem_we, ir_we, reg_we;

    assign wait_done = (wait_reg == 4'd0);

    // DECODE dispatch: only beq (funct3=000) is a legal branch.
    function automatic logic [3:0] decode_target(input logic [6:0] op, input logic [2:0] f3);
        logic [3:0] t;
        t = S_ILLEGAL;
        case (op)
            OP_LW, OP_SW: t = S_MEMADDR;
            OP_R:         t = S_EXEC_R;
            OP_I:         t = S_EXEC_I;
            OP_BRANCH:    t = (f3 == 3'b000) ? S_BRANCH : S_ILLEGAL;
            OP_JAL:       t = S_JAL;
            default:      t = S_ILLEGAL;
        endcase
        return t;
    endfunction

    // State and wait counter; reset lands in FETCH with a full wait count.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            wait_reg  <= WAIT_INIT;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // Next-state logic; memory states hold while the wait counter drains.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            S_FETCH: begin
                if (!wait_done) wait_next = wait_reg - 4'd1;
                else            state_next = S_DECODE;
            end
            S_DECODE:  state_next = decode_target(opcode, funct3);
            S_MEMADDR: state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (!wait_done) wait_next = wait_reg - 4'd1;
                else            state_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (!wait_done) wait_next = wait_reg - 4'd1;
                else            state_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I:        state_next = S_ALU_WB;
            S_MEMWB, S_ALU_WB,
            S_BRANCH, S_JAL:           state_next = S_FETCH;
`ifdef RV32_MC_ILLEGAL_TRAP_EN
            S_TRAP:                    state_next = S_TRAP;
`endif
            default:                   state_next = S_FETCH;
        endcase
        // Reload the wait count whenever a memory state is freshly entered.
        if ((state_next != state_reg) &&
            ((state_next == S_FETCH) || (state_next == S_MEMREAD) || (state_next == S_MEMWRITE)))
            wait_next = WAIT_INIT;
    end

    // Moore output decode from the current state.
    always_comb begin
        pc_we    = 1'b0;
        pcc_we   = 1'b0;
        mem_we   = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        IouD     = 1'b0;
        LeMem    = 1'b0;
        Mem2Reg  = 2'b00;
        OrigPC   = 2'b00;
        OrigAULA = 2'b00;
        OrigBULA = 2'b00;
        ALUOp    = 2'b00;
        case (state_reg)
            S_FETCH: begin
                LeMem    = 1'b1;
                OrigBULA = 2'b01;
                ir_we    = wait_done;
                pc_we    = wait_done;
            end
            S_DECODE: begin
                OrigAULA = 2'b10;
                OrigBULA = 2'b10;
            end
            S_MEMADDR: begin
                OrigAULA = 2'b01;
                OrigBULA = 2'b10;
            end
            S_MEMREAD: begin
                IouD  = 1'b1;
                LeMem = 1'b1;
            end
            S_MEMWB: begin
                reg_we  = 1'b1;
                Mem2Reg = 2'b01;
            end
            S_MEMWRITE: begin
                IouD   = 1'b1;
                mem_we = wait_done;
            end
            S_EXEC_R: begin
                OrigAULA = 2'b01;
                ALUOp    = 2'b10;
            end
            S_EXEC_I: begin
                OrigAULA = 2'b01;
                OrigBULA = 2'b10;
                ALUOp    = 2'b11;
            end
            S_ALU_WB: begin
                reg_we = 1'b1;
            end
            S_BRANCH: begin
                OrigAULA = 2'b01;
                ALUOp    = 2'b01;
                pcc_we   = 1'b1;
                OrigPC   = 2'b01;
            end
            S_JAL: begin
                pc_we   = 1'b1;
                OrigPC  = 2'b10;
                reg_we  = 1'b1;
                Mem2Reg = 2'b10;
            end
            default: begin
            end
        endcase
    end

    // Reset parks the FSM in FETCH, which would otherwise fire the fetch
    // pulse when MEM_WAIT=0; gating keeps every write quiet during reset.
    assign EscrevePC     = pc_we  & ~reset;
    assign EscrevePCCond = pcc_we & ~reset;
    assign EscreveMem    = mem_we & ~reset;
    assign EscreveIR     = ir_we  & ~reset;
    assign EscreveReg    = reg_we & ~reset;
    assign estado        = state_reg;

`ifdef RV32_MC_ILLEGAL_TRAP_EN
    assign halt = (state_reg == S_TRAP);
`else
    assign halt = 1'b0;
`endif

endmodule
